// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : addsub_arbiter_if
// Brief    : Command/response bundle between two requesters, the arbiter and
//            the result consumer.
// Revision : 1.0
// =============================================================================
interface addsub_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_a;
    logic [2:0] req0_b;
    logic       req0_s;
    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_a;
    logic [2:0] req1_b;
    logic       req1_s;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_c;
    logic       rsp_id;
    logic       rsp_err;

    // master: command sources and result consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_s,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_s,
        input  req1_ready,
        input  rsp_valid, rsp_c, rsp_id, rsp_err,
        output rsp_ready
    );

    // slave: the arbiter
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_s,
        output req1_ready,
        output rsp_valid, rsp_c, rsp_id, rsp_err,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : addsub_arbiter
// Brief    : Two-requester arbiter sharing one combinational sign-magnitude
//            add/sub unit; returns the captured result with id and error flag.
// Revision : 1.0
// =============================================================================
module addsub_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    addsub_arbiter_if.slave bus,
    output logic [2:0]      au_a,
    output logic [2:0]      au_b,
    output logic            au_s,
    input  wire logic [4:0] au_c,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state_q;
    logic       prio_q;
    logic [2:0] a_q;
    logic [2:0] b_q;
    logic       s_q;
    logic       id_q;
    logic [4:0] rsp_c_q;
    logic       rsp_id_q;
    logic       rsp_err_q;
    logic       rsp_valid_q;
    logic       busy_q;

    logic       prio_eff;
    logic       gnt0;
    logic       gnt1;
    logic       acc0;
    logic       acc1;
    logic [2:0] a_d;
    logic [2:0] b_d;
    logic       s_d;

    // -0 is folded to +0 so the shared unit never sees a negative zero
    function automatic logic [2:0] norm_zero(input logic [2:0] x);
        return (x == 3'b100) ? 3'b000 : x;
    endfunction

    always_comb begin
        prio_eff = FAIR ? prio_q : 1'b0;
        gnt1     = bus.req1_valid & (~bus.req0_valid | prio_eff);
        gnt0     = bus.req0_valid & ~gnt1;
        a_d      = norm_zero(gnt1 ? bus.req1_a : bus.req0_a);
        b_d      = norm_zero(gnt1 ? bus.req1_b : bus.req0_b);
        s_d      = gnt1 ? bus.req1_s : bus.req0_s;
    end

    // rst_n gates the readies so nothing handshakes while reset is held
    assign acc0 = rst_n & (state_q == S_IDLE) & gnt0;
    assign acc1 = rst_n & (state_q == S_IDLE) & gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            a_q         <= 3'b000;
            b_q         <= 3'b000;
            s_q         <= 1'b0;
            id_q        <= 1'b0;
            rsp_c_q     <= 5'b00000;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc0 | acc1) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        s_q     <= s_d;
                        id_q    <= acc1;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_c_q     <= au_c;
                    rsp_err_q   <= (au_c[3:0] > 4'd6) | (au_c == 5'b10000);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        prio_q      <= ~rsp_id_q;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
    assign au_a           = a_q;
    assign au_b           = b_q;
    assign au_s           = s_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one combinational 3-bit sign-magnitude add/sub unit (`add_sub`) between two requesters. It accepts operand/op commands over valid/ready handshakes, arbitrates round-robin and drives the shared unit from registered operands. It then captures the 5-bit sign-magnitude result and returns it with the requester ID and an integrity flag. It sits between the calculator front-end command sources and the `add_sub` instance.

## Interface
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with requester 0 always winning.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a command.
- `req0_ready` out 1: requester 0's command is accepted at this edge.
- `req0_a` in 3: operand a, sign-magnitude; bit 2 is the sign, bits 1:0 the magnitude.
- `req0_b` in 3: operand b, same format as `req0_a`.
- `req0_s` in 1: 0 = add, 1 = subtract.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_s`: same as the requester 0 ports, for requester 1.
- `rsp_valid` out 1: a result is held.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_c` out 5: result; bit 4 is the sign, bits 3:0 the magnitude.
- `rsp_id` out 1: the requester that issued the command.
- `rsp_err` out 1: the result failed the sanity check.
- `au_a` out 3: operand a to `add_sub`.
- `au_b` out 3: operand b to `add_sub`.
- `au_s` out 1: op select to `add_sub`.
- `au_c` in 5: result from `add_sub`.
- `busy` out 1: the block is not in IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE: grant.**
  - The grant is computed combinationally from the two valids.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester with priority is granted.
  - `reqk_ready = (state==IDLE) & grant_k`. At most one ready is high per cycle.
  - On an edge with a ready/valid handshake:
    - latch a, b, s and the id;
    - go to EXEC.
- **Negative-zero normalisation (on latch).** An operand equal to 3'b100 (−0) is stored as 3'b000.
- **EXEC.**
  - `au_a`/`au_b`/`au_s` are driven from the latched registers. They are driven from the registers in every state and never directly from the request ports.
  - At the end of EXEC:
    - `rsp_c <= au_c`;
    - `rsp_err <= (au_c[3:0] > 6) | (au_c == 5'b10000)`;
    - go to RESP.
- **RESP.**
  - `rsp_valid` = 1.
  - `rsp_c`, `rsp_id` and `rsp_err` are held stable until the handshake.
  - On `rsp_valid & rsp_ready` at an edge, return to IDLE.
- **Priority pointer.**
  - It changes on the response handshake: priority goes to the requester that was not just served.
  - When `FAIR`=0, the pointer is ignored and requester 0 always has priority.
- A requester may drop `valid` before acceptance; no command is latched in that case.

## Timing
- **Reset values (asynchronous, immediate):**
  - state IDLE;
  - priority pointer → requester 0;
  - `rsp_valid`=0, `rsp_c`=0, `rsp_id`=0, `rsp_err`=0;
  - `au_a`=0, `au_b`=0, `au_s`=0;
  - `busy`=0.
- **Reset mid-operation:** any in-flight command is dropped with no response, and no ready is asserted while `rst_n`=0.
- **Latency:** command accepted at edge N → result captured at edge N+1 → `rsp_valid` high from edge N+1 until the response handshake.
- **Throughput:** with `rsp_ready` tied high, at most one command every 3 cycles. Edges are N (accept), N+1 (capture), N+2 (response handshake); the next accept is at N+3.
- **Ready:** no ready is high in EXEC or RESP, and requests arriving then wait.
- **Simultaneous events:** a new request valid in the same cycle as the response handshake is not granted until the following IDLE cycle, and it sees the already-updated pointer.
- **`busy`** is high in EXEC and RESP.

## Test plan
- **Single add:** requester 0 sends a=3'b011 (+3), b=3'b010 (+2), s=0 → one cycle later `rsp_valid`=1, `rsp_c`=5'b00101, `rsp_id`=0, `rsp_err`=0.
- **Subtract:**
  - requester 1 sends a=3'b111 (−3), b=3'b101 (−1), s=1 → `rsp_c`=5'b10010, `rsp_id`=1;
  - +1 − +3 → 5'b10010.
- **Contention, `FAIR`=1:** both requesters continuously valid → grants alternate 0,1,0,1 across 4 commands, each accept 3 cycles apart.
- **Contention, `FAIR`=0:** both requesters continuously valid → requester 0 always granted and requester 1 starves while requester 0 stays valid.
- **Backpressure and normalisation:**
  - hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable, `req*_ready`=0 throughout;
  - a=3'b100 (−0) → `au_a`=3'b000.
- **Integrity and reset:**
  - a stub that forces `au_c`=5'b10000 or 5'b00111 → `rsp_err`=1;
  - `rst_n` pulsed low during EXEC → all outputs 0 immediately and no response is produced.
